// File: rtl/adder_ring_counter.sv
// Measurement sequencer for the instrumented adder: latches operands, runs the ring loop,
// waits a settle period, then counts synchronised rising edges of the chain output over a window.
module adder_ring_counter #(
   parameter int WIDTH         = 32,
   parameter int CNT_W         = 32,
   parameter int SETTLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             active,
   input  logic             start,
   input  logic [31:0]      window,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             ring_in,
   output logic [WIDTH-1:0] a_input,
   output logic [WIDTH-1:0] b_input,
   output logic             run,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      COUNT,
      DONE
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ring_prev;
   logic                   ring_rise;
   logic [31:0]            window_reg;
   logic [31:0]            window_cnt;
   logic [SET_W-1:0]       settle_cnt;

   // The chain output is asynchronous; it is resynchronised in every state so the
   // edge detector is already primed when counting begins.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync_q    <= '0;
         ring_prev <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], ring_in};
         ring_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign ring_rise = sync_q[SYNC_STAGES-1] & ~ring_prev;

   // Sequencer; dropping active outside IDLE abandons the measurement without a done pulse
   // and leaves the partial count visible.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         a_input    <= '0;
         b_input    <= '0;
         run        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         count      <= '0;
         overflow   <= 1'b0;
         window_reg <= '0;
         window_cnt <= '0;
         settle_cnt <= '0;
      end else if (state != IDLE && !active) begin
         state <= IDLE;
         run   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && active) begin
                  a_input    <= a_in;
                  b_input    <= b_in;
                  window_reg <= window;
                  count      <= '0;
                  overflow   <= 1'b0;
                  settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
                  run        <= 1'b1;
                  busy       <= 1'b1;
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  if (window_reg == 32'd0) begin
                     run   <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     window_cnt <= window_reg - 32'd1;
                     state      <= COUNT;
                  end
               end else begin
                  settle_cnt <= settle_cnt - SET_W'(1);
               end
            end
            COUNT: begin
               // Saturate rather than wrap so a too-long window is visible as overflow.
               if (ring_rise) begin
                  if (&count) begin
                     overflow <= 1'b1;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
               if (window_cnt == 32'd0) begin
                  run   <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  window_cnt <= window_cnt - 32'd1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               run   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
